// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types for the register-file write-port arbiter
package wb_arb_pkg;

   localparam int DATA_WIDTH   = 64;
   localparam int REG_ID_WIDTH = 5;

   typedef struct packed {
      logic [REG_ID_WIDTH-1:0] dest;
      logic [DATA_WIDTH-1:0]   data;
   } wb_req_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_PIPE,
      GNT_SEC
   } grant_e;

endpackage

// File: rtl/wb_sec_fifo.sv
// rtl/wb_sec_fifo.sv - synchronous FIFO holding queued secondary writeback requests
module wb_sec_fifo
   import wb_arb_pkg::wb_req_t;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  wb_req_t                    push_data,
   input  logic                       pop,
   output wb_req_t                    pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_req_t          mem_q [DEPTH];
   wb_req_t          mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between pipeline writeback and mul/div results
// Optional perf counters enabled by WB_PORT_ARB_PERF_EN.
module wb_port_arbiter
   import wb_arb_pkg::wb_req_t;
   import wb_arb_pkg::grant_e;
   import wb_arb_pkg::GNT_NONE;
   import wb_arb_pkg::GNT_PIPE;
   import wb_arb_pkg::GNT_SEC;
#(
   parameter int DATA_WIDTH   = 64,
   parameter int REG_ID_WIDTH = 5,
   parameter int FIFO_DEPTH   = 4,
   parameter int MAX_WAIT     = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wb_reg_write,
   input  logic [REG_ID_WIDTH-1:0] wb_dest,
   input  logic [DATA_WIDTH-1:0]   wb_data,
   input  logic                    sec_valid,
   output logic                    sec_ready,
   input  logic [REG_ID_WIDTH-1:0] sec_dest,
   input  logic [DATA_WIDTH-1:0]   sec_data,
   output logic                    rf_we,
   output logic [REG_ID_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]   rf_wdata,
`ifdef WB_PORT_ARB_PERF_EN
   output logic [31:0]             perf_stall_cnt,
   output logic [31:0]             perf_conflict_cnt,
`endif
   output logic                    pipe_stall
);

   localparam int WAIT_W = $clog2(MAX_WAIT+1);
   localparam int CNT_W  = $clog2(FIFO_DEPTH+1);

   logic                    rf_we_q, rf_we_d;
   logic [REG_ID_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
   logic                    pipe_stall_q, pipe_stall_d;
   logic [WAIT_W-1:0]       wait_q, wait_d;

   logic        pipe_req, push, pop, head_waiting, fifo_occupied;
   logic        fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   grant_e      grant;
   wb_req_t     sec_req, head;

   assign sec_req.dest  = sec_dest;
   assign sec_req.data  = sec_data;
   assign fifo_occupied = (fifo_count != '0);

   wb_sec_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_sec_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (sec_req),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      // A stalled MEM/WB stage re-presents the same instruction; drop it here.
      pipe_req  = wb_reg_write && (wb_dest != '0) && !pipe_stall_q;
      sec_ready = !fifo_full && !reset;
      push      = sec_valid && sec_ready && (sec_dest != '0);

      grant = GNT_NONE;
      if (pipe_req) begin
         grant = GNT_PIPE;
      end else if (!fifo_empty) begin
         grant = GNT_SEC;
      end
      pop = (grant == GNT_SEC);

      rf_we_d    = (grant != GNT_NONE);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (grant == GNT_PIPE) begin
         rf_waddr_d = wb_dest;
         rf_wdata_d = wb_data;
      end else if (grant == GNT_SEC) begin
         rf_waddr_d = head.dest;
         rf_wdata_d = head.data;
      end

      head_waiting = fifo_occupied && (grant != GNT_SEC);
      wait_d       = head_waiting ? wait_q + 1'b1 : '0;
      pipe_stall_d = head_waiting && (wait_d == WAIT_W'(MAX_WAIT)) && !pipe_stall_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         pipe_stall_q <= 1'b0;
         wait_q       <= '0;
      end else begin
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         pipe_stall_q <= pipe_stall_d;
         wait_q       <= wait_d;
      end
   end

   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign pipe_stall = pipe_stall_q;

`ifdef WB_PORT_ARB_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_conflict_q, perf_conflict_d;

   always_comb begin
      perf_stall_d    = perf_stall_q;
      perf_conflict_d = perf_conflict_q;
      if (pipe_stall_q && !(&perf_stall_q)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (pipe_req && fifo_occupied && !(&perf_conflict_q)) begin
         perf_conflict_d = perf_conflict_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_q    <= '0;
         perf_conflict_q <= '0;
      end else begin
         perf_stall_q    <= perf_stall_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_stall_cnt    = perf_stall_q;
   assign perf_conflict_cnt = perf_conflict_q;
`endif

endmodule
